// File: rtl/vx_dcache_ser_pkg.sv
// Shared types for the dcache request serializer: lane-index width helper,
// per-lane request record and the two-state view of the pending mask.
package vx_dcache_ser_pkg;

  localparam int REQ_WORD_SIZE  = 4;
  localparam int REQ_ADDR_WIDTH = 30;
  localparam int REQ_TAG_WIDTH  = 8;

  function automatic int lane_bits(input int num_reqs);
    return (num_reqs > 1) ? $clog2(num_reqs) : 1;
  endfunction

  typedef struct packed {
    logic                         rw;
    logic [REQ_WORD_SIZE-1:0]     byteen;
    logic [REQ_ADDR_WIDTH-1:0]    addr;
    logic [8*REQ_WORD_SIZE-1:0]   data;
    logic [REQ_TAG_WIDTH-1:0]     tag;
  } lane_req_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } ser_state_e;

endpackage

// File: rtl/vx_lane_priority_enc.sv
// Lowest-set-bit encoder for the pending lane mask: index, one-hot of that
// bit, and a flag telling whether the whole mask holds exactly one lane.
module vx_lane_priority_enc #(
  parameter int N  = 4,
  parameter int LB = 2
) (
  input  logic [N-1:0]  mask_i,
  output logic [LB-1:0] idx_o,
  output logic [N-1:0]  onehot_o,
  output logic          onehot_flag_o
);

  always_comb begin
    idx_o    = '0;
    onehot_o = '0;
    // Scan downward so the lowest set bit is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (mask_i[i]) begin
        idx_o       = LB'(i);
        onehot_o    = '0;
        onehot_o[i] = 1'b1;
      end
    end
  end

  assign onehot_flag_o = (mask_i != '0) && ((mask_i & (mask_i - N'(1))) == '0);

endmodule

// File: rtl/vx_dcache_req_serializer.sv
// Captures a multi-lane LSU request batch and issues the valid lanes one per
// cycle to a single-port dcache, tagging each request with its lane index.
module vx_dcache_req_serializer
  import vx_dcache_ser_pkg::*;
#(
  parameter int NUM_REQS   = 4,
  parameter int WORD_SIZE  = REQ_WORD_SIZE,
  parameter int ADDR_WIDTH = REQ_ADDR_WIDTH,
  parameter int TAG_WIDTH  = REQ_TAG_WIDTH,
  parameter int LANE_BITS  = lane_bits(NUM_REQS)
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [NUM_REQS-1:0]               in_valid,
  input  logic [NUM_REQS-1:0]               in_rw,
  input  logic [NUM_REQS*WORD_SIZE-1:0]     in_byteen,
  input  logic [NUM_REQS*ADDR_WIDTH-1:0]    in_addr,
  input  logic [NUM_REQS*8*WORD_SIZE-1:0]   in_data,
  input  logic [NUM_REQS*TAG_WIDTH-1:0]     in_tag,
  output logic [NUM_REQS-1:0]               in_ready,
  output logic                              out_valid,
  output logic                              out_rw,
  output logic [WORD_SIZE-1:0]              out_byteen,
  output logic [ADDR_WIDTH-1:0]             out_addr,
  output logic [8*WORD_SIZE-1:0]            out_data,
  output logic [LANE_BITS+TAG_WIDTH-1:0]    out_tag,
  input  logic                              out_ready
);

  // The lane record is sized by the package; keep the module widths in step.
  if (WORD_SIZE != REQ_WORD_SIZE || ADDR_WIDTH != REQ_ADDR_WIDTH ||
      TAG_WIDTH != REQ_TAG_WIDTH) begin : g_width_check
    $error("vx_dcache_req_serializer: widths must match vx_dcache_ser_pkg");
  end

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; valid never drops and payload never changes until that edge.

  logic [NUM_REQS-1:0]  mask_q, mask_d;
  lane_req_t            lane_q [NUM_REQS];
  lane_req_t            lane_in [NUM_REQS];
  ser_state_e           state;
  logic [LANE_BITS-1:0] cur_idx;
  logic [NUM_REQS-1:0]  cur_onehot;
  logic                 last_lane;
  logic                 ready_all;
  logic                 accept;
  logic                 fire;

  vx_lane_priority_enc #(
    .N  (NUM_REQS),
    .LB (LANE_BITS)
  ) u_prio (
    .mask_i        (mask_q),
    .idx_o         (cur_idx),
    .onehot_o      (cur_onehot),
    .onehot_flag_o (last_lane)
  );

  assign state     = (mask_q != '0) ? ST_SEND : ST_IDLE;
  assign fire      = (state == ST_SEND) && out_ready;
  assign ready_all = (state == ST_IDLE) || ((state == ST_SEND) && last_lane && out_ready);
  assign accept    = (|in_valid) && ready_all;
  assign in_ready  = {NUM_REQS{ready_all}};

  always_comb begin
    for (int i = 0; i < NUM_REQS; i++) begin
      lane_in[i].rw     = in_rw[i];
      lane_in[i].byteen = in_byteen[i*WORD_SIZE +: WORD_SIZE];
      lane_in[i].addr   = in_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      lane_in[i].data   = in_data[i*8*WORD_SIZE +: 8*WORD_SIZE];
      lane_in[i].tag    = in_tag[i*TAG_WIDTH +: TAG_WIDTH];
    end
  end

  always_comb begin
    mask_d = mask_q;
    if (fire) begin
      mask_d = mask_q & ~cur_onehot;
    end
    // A new batch only lands when the old one is empty or retiring now.
    if (accept) begin
      mask_d = in_valid;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q <= '0;
    end else begin
      mask_q <= mask_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REQS; i++) begin
        lane_q[i] <= '0;
      end
    end else if (accept) begin
      for (int i = 0; i < NUM_REQS; i++) begin
        lane_q[i] <= lane_in[i];
      end
    end
  end

  assign out_valid  = (state == ST_SEND);
  assign out_rw     = lane_q[cur_idx].rw;
  assign out_byteen = lane_q[cur_idx].byteen;
  assign out_addr   = lane_q[cur_idx].addr;
  assign out_data   = lane_q[cur_idx].data;
  assign out_tag    = {cur_idx, lane_q[cur_idx].tag};

endmodule

// File: tb/tb_vx_dcache_req_serializer.sv
// Bench for the dcache request serializer: directed vector table, corner
// sequences, then random traffic checked against a transaction-queue model.
module tb_vx_dcache_req_serializer;

  localparam int N  = 4;
  localparam int WS = 4;
  localparam int AW = 30;
  localparam int TW = 8;
  localparam int LB = 2;
  localparam int W  = 1 + WS + AW + 8*WS + LB + TW;

  logic              clk;
  logic              reset_n;
  logic [N-1:0]      in_valid;
  logic [N-1:0]      in_rw;
  logic [N*WS-1:0]   in_byteen;
  logic [N*AW-1:0]   in_addr;
  logic [N*8*WS-1:0] in_data;
  logic [N*TW-1:0]   in_tag;
  logic [N-1:0]      in_ready;
  logic              out_valid;
  logic              out_rw;
  logic [WS-1:0]     out_byteen;
  logic [AW-1:0]     out_addr;
  logic [8*WS-1:0]   out_data;
  logic [LB+TW-1:0]  out_tag;
  logic              out_ready;

  vx_dcache_req_serializer #(
    .NUM_REQS (N)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_rw      (in_rw),
    .in_byteen  (in_byteen),
    .in_addr    (in_addr),
    .in_data    (in_data),
    .in_tag     (in_tag),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_rw     (out_rw),
    .out_byteen (out_byteen),
    .out_addr   (out_addr),
    .out_data   (out_data),
    .out_tag    (out_tag),
    .out_ready  (out_ready)
  );

  // Clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: expected serialized requests, oldest first
  logic [W-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;
  int fire_cnt = 0;
  logic offer_pending = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic model_ready();
    return (exp_q.size() == 0) || (exp_q.size() == 1 && out_ready);
  endfunction

  task automatic check_model();
    logic [W-1:0] act;
    check("in_ready", 128'(in_ready), model_ready() ? 128'({N{1'b1}}) : 128'(0));
    check("out_valid", 128'(out_valid), 128'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      act = {out_rw, out_byteen, out_addr, out_data, out_tag};
      check("out_req", 128'(act), 128'(exp_q[0]));
    end
  endtask

  // Applied at the rising edge with the inputs held over that edge.
  task automatic model_update();
    logic rdy;
    logic acc;
    rdy = model_ready();
    acc = (|in_valid) && rdy;
    if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
    if (acc) begin
      for (int i = 0; i < N; i++) begin
        if (in_valid[i]) begin
          exp_q.push_back({in_rw[i], in_byteen[i*WS +: WS], in_addr[i*AW +: AW],
                           in_data[i*8*WS +: 8*WS], LB'(i), in_tag[i*TW +: TW]});
        end
      end
    end
    offer_pending = (|in_valid) && !acc;
  endtask

  // Driver tasks
  task automatic randomize_fields();
    for (int i = 0; i < N; i++) begin
      in_rw[i]              = 1'($urandom_range(0, 1));
      in_byteen[i*WS +: WS] = WS'($urandom);
      in_addr[i*AW +: AW]   = AW'($urandom);
      in_data[i*8*WS +: 8*WS] = (8*WS)'($urandom);
      in_tag[i*TW +: TW]    = TW'($urandom);
    end
  endtask

  task automatic step();
    #1;
    check_model();
    if (out_valid && out_ready) fire_cnt++;
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  typedef struct {
    logic [N-1:0]  iv;
    logic          ordy;
    logic          new_fields;
    logic          exp_rdy;
    logic          exp_ov;
    logic [LB-1:0] exp_lane;
  } vec_t;

  vec_t vec[26];
  int   f0;

  initial begin
    // Batch 1011, full throughput
    vec[0]  = '{4'b1011, 1, 1, 1, 0, 0};
    vec[1]  = '{4'b0000, 1, 0, 0, 1, 0};
    vec[2]  = '{4'b0000, 1, 0, 0, 1, 1};
    vec[3]  = '{4'b0000, 1, 0, 1, 1, 3};
    vec[4]  = '{4'b0000, 1, 0, 1, 0, 0};
    // Batch 1011 with out_ready low for 3 cycles on lane 1
    vec[5]  = '{4'b1011, 1, 1, 1, 0, 0};
    vec[6]  = '{4'b0000, 1, 0, 0, 1, 0};
    vec[7]  = '{4'b0000, 0, 0, 0, 1, 1};
    vec[8]  = '{4'b0000, 0, 0, 0, 1, 1};
    vec[9]  = '{4'b0000, 0, 0, 0, 1, 1};
    vec[10] = '{4'b0000, 1, 0, 0, 1, 1};
    vec[11] = '{4'b0000, 1, 0, 1, 1, 3};
    vec[12] = '{4'b0000, 1, 0, 1, 0, 0};
    // Back-to-back 0001 then 1111
    vec[13] = '{4'b0001, 1, 1, 1, 0, 0};
    vec[14] = '{4'b1111, 1, 1, 1, 1, 0};
    vec[15] = '{4'b0000, 1, 0, 0, 1, 0};
    vec[16] = '{4'b0000, 1, 0, 0, 1, 1};
    vec[17] = '{4'b0000, 1, 0, 0, 1, 2};
    vec[18] = '{4'b0000, 1, 0, 1, 1, 3};
    vec[19] = '{4'b0000, 1, 0, 1, 0, 0};
    // New batch offered while the last lane is stalled
    vec[20] = '{4'b0100, 0, 1, 1, 0, 0};
    vec[21] = '{4'b0010, 0, 1, 0, 1, 2};
    vec[22] = '{4'b0010, 0, 0, 0, 1, 2};
    vec[23] = '{4'b0010, 1, 0, 1, 1, 2};
    vec[24] = '{4'b0000, 1, 0, 1, 1, 1};
    vec[25] = '{4'b0000, 1, 0, 1, 0, 0};

    reset_n   = 1'b0;
    in_valid  = '0;
    in_rw     = '0;
    in_byteen = '0;
    in_addr   = '0;
    in_data   = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("reset_out_valid", 128'(out_valid), 128'(0));
    check("reset_in_ready", 128'(in_ready), 128'(4'b1111));
    check("reset_out_data", 128'(out_data), 128'(0));
    check("reset_out_tag", 128'(out_tag), 128'(0));
    @(negedge clk);
    reset_n = 1'b1;

    for (int k = 0; k < 26; k++) begin
      if (vec[k].new_fields) randomize_fields();
      in_valid  = vec[k].iv;
      out_ready = vec[k].ordy;
      if (k == 14) f0 = fire_cnt;
      #1;
      check($sformatf("vec%0d_in_ready", k), 128'(in_ready[0]), 128'(vec[k].exp_rdy));
      check($sformatf("vec%0d_out_valid", k), 128'(out_valid), 128'(vec[k].exp_ov));
      if (vec[k].exp_ov) begin
        check($sformatf("vec%0d_lane", k), 128'(out_tag[TW +: LB]), 128'(vec[k].exp_lane));
      end
      if (k == 19) check("b2b_fires", 128'(fire_cnt - f0), 128'(5));
      step();
    end

    // Zero mask for 10 cycles
    in_valid = '0;
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #1;
      check("zero_out_valid", 128'(out_valid), 128'(0));
      step();
    end

    // Write lane with exact field values
    randomize_fields();
    in_rw[2]              = 1'b1;
    in_byteen[2*WS +: WS] = 4'b0110;
    in_addr[2*AW +: AW]   = 30'h100;
    in_data[2*8*WS +: 32] = 32'hDEADBEEF;
    in_tag[2*TW +: TW]    = 8'h5A;
    in_valid = 4'b0100;
    step();
    in_valid = '0;
    #1;
    check("wr_rw", 128'(out_rw), 128'(1));
    check("wr_byteen", 128'(out_byteen), 128'(4'b0110));
    check("wr_addr", 128'(out_addr), 128'(30'h100));
    check("wr_data", 128'(out_data), 128'(32'hDEADBEEF));
    check("wr_tag", 128'(out_tag), 128'(10'h25A));
    step();
    step();

    // Reset in the middle of a 4-lane batch
    randomize_fields();
    in_valid = 4'b1111;
    step();
    in_valid = '0;
    step();
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_out_valid", 128'(out_valid), 128'(0));
    check("midrst_in_ready", 128'(in_ready), 128'(4'b1111));
    exp_q.delete();
    offer_pending = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("postrst_out_valid", 128'(out_valid), 128'(0));
      step();
    end

    // Random traffic against the queue model
    for (int k = 0; k < 400; k++) begin
      if (!offer_pending) begin
        randomize_fields();
        in_valid = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    in_valid = '0;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) step();
    check("drain_empty", 128'(out_valid), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
